// File: rtl/knight_fade.sv
// knight_fade: per-LED decaying brightness with PWM output, giving the scanner an afterglow trail
// Ports:
//   ck   - system clock, rising edge
//   res  - asynchronous active-low reset
//   pat  - 8-bit LED pattern from the scanner, bit i high loads LED i to full brightness
//   led  - registered PWM drive to the LEDs
//   busy - registered, high while any LED level is non-zero
module knight_fade #(
    parameter int BW        = 4,
    parameter int DECAY_DIV = 16
) (
    input  logic       ck,
    input  logic       res,
    input  logic [7:0] pat,
    output logic [7:0] led,
    output logic       busy
);
    localparam logic [BW-1:0] MAX = '1;
    localparam int DW = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);

    logic [BW-1:0] level [8];
    logic [BW-1:0] cnt;
    logic [DW-1:0] div;
    logic [7:0]    nz;
    logic          tick;

    assign tick = div == DLAST;

    always_comb begin
        nz = '0;
        for (int i = 0; i < 8; i++) nz[i] = level[i] != '0;
    end

    // cnt spans 0..MAX-1 so a level of MAX lights every slot and 0 lights none.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            level <= '{default: '0};
            cnt   <= '0;
            div   <= '0;
            led   <= '0;
            busy  <= 1'b0;
        end else begin
            cnt  <= cnt == MAX - 1'b1 ? '0 : cnt + 1'b1;
            div  <= tick ? '0 : div + 1'b1;
            busy <= |nz;
            for (int i = 0; i < 8; i++) begin
                level[i] <= pat[i] ? MAX : (tick && nz[i]) ? level[i] - 1'b1 : level[i];
                led[i]   <= level[i] > cnt;
            end
        end
    end
endmodule

// File: tb/tb_knight_fade.sv
// tb_knight_fade: self-checking bench for knight_fade with a behavioural scoreboard and vector table
module tb_knight_fade;
    localparam int BW = 4;
    localparam int DD = 4;
    localparam int MX = 15;

    logic       ck = 1'b0;
    logic       res = 1'b1;
    logic [7:0] pat = '0;
    logic [7:0] led;
    logic       busy;

    knight_fade #(.BW(BW), .DECAY_DIV(DD)) dut (
        .ck  (ck),
        .res (res),
        .pat (pat),
        .led (led),
        .busy(busy)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [7:0] p;
        int         n;
        logic [7:0] el;
        logic       eb;
    } vec_t;

    int pass_n = 0;
    int total_n = 0;
    int lvl[8];
    int mcnt;
    int mdiv;
    logic [8:0] sb[$];

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) lvl[i] = 0;
        mcnt = 0;
        mdiv = 0;
        sb.delete();
    endtask

    // Expected outputs come from the pre-edge model state; the model then advances one clock.
    task automatic step(input logic [7:0] p);
        logic [8:0] e;
        bit tk;
        pat = p;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[i] = lvl[i] > mcnt;
            if (lvl[i] != 0) e[8] = 1'b1;
        end
        sb.push_back(e);
        tk = (mdiv == DD - 1);
        for (int i = 0; i < 8; i++) begin
            if (p[i]) lvl[i] = MX;
            else if (tk && lvl[i] > 0) lvl[i] = lvl[i] - 1;
        end
        mcnt = (mcnt + 1) % MX;
        mdiv = (mdiv + 1) % DD;
        @(posedge ck);
        #1;
        chk("model", {busy, led}, sb.pop_front());
    endtask

    task automatic do_reset();
        pat = '0;
        res = 1'b0;
        repeat (2) @(posedge ck);
        @(negedge ck);
        res = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int n;
        tbl[0] = '{8'h00, 5, 8'h00, 1'b0};
        tbl[1] = '{8'h01, 2, 8'h01, 1'b1};
        tbl[2] = '{8'hA5, 3, 8'hA5, 1'b1};
        tbl[3] = '{8'h3C, 1, 8'h00, 1'b0};
        tbl[4] = '{8'hFF, 2, 8'hFF, 1'b1};
        tbl[5] = '{8'h80, 100, 8'h80, 1'b1};

        // reset held with pat high and clocks running
        #1 res = 1'b0;
        pat = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(posedge ck);
            #1;
            chk("rst_hold", {busy, led}, 9'h000);
        end
        @(negedge ck);
        res = 1'b1;
        model_reset();
        step(8'hFF);
        chk("rst_edge1", {busy, led}, 9'h000);
        for (int i = 0; i < 6; i++) begin
            step(8'hFF);
            chk("rst_solid", {busy, led}, 9'h1FF);
        end

        // vector table, each record from a fresh reset
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int c = 0; c < tbl[v].n; c++) step(tbl[v].p);
            chk($sformatf("vec%0d", v), {busy, led}, {tbl[v].eb, tbl[v].el});
        end

        // single pulse aligned to a tick edge: level hits 0 at edge 64, busy falls at edge 65
        do_reset();
        repeat (3) step(8'h00);
        step(8'h01);
        n = 0;
        do begin
            step(8'h00);
            n++;
        end while (busy === 1'b1 && n < 200);
        chk("fade_len", 9'(n), 9'd61);

        // collision: load on the tick that would take level 5 to 4
        do_reset();
        repeat (3) step(8'h00);
        step(8'h08);
        repeat (43) step(8'h00);
        step(8'h08);
        for (int i = 0; i < 4; i++) begin
            step(8'h00);
            chk("collision", {8'h00, led[3]}, 9'h001);
        end

        // walking one sweep
        do_reset();
        for (int j = 0; j < 8; j++) begin
            step(8'(1 << j));
            repeat (3) step(8'h00);
        end
        repeat (70) step(8'h00);
        chk("sweep_idle", {busy, led}, 9'h000);

        // asynchronous reset mid-fade at level 9
        do_reset();
        repeat (3) step(8'h00);
        step(8'h01);
        repeat (25) step(8'h00);
        chk("pre_async", {8'h00, busy}, 9'h001);
        #2 res = 1'b0;
        #1 chk("async_clr", {busy, led}, 9'h000);
        @(negedge ck);
        res = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step(8'h00);
            chk("post_rst", {busy, led}, 9'h000);
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/knight_fade.md
Name: knight_fade

Overview:
- Downstream stage of the knight scanner.
- Consumes the scanner's 8-bit LED pattern and turns each lit position into a per-LED brightness level that decays over time, giving the moving light a fading "afterglow" trail.
- Drives the physical LEDs with PWM derived from those levels.
- Sits between the scanner output and the board LED pins.

Parameters:
- BW, 4, brightness level width in bits; MAX = 2^BW-1.
- DECAY_DIV, 16, clocks per decay step (>=1).

Ports:
- ck  input  1  system clock, all state updates on rising edge.
- res  input  1  reset; asynchronous, active-low (0 = reset).
- pat  input  8  LED pattern from scanner; bit i high = position i currently lit.
- led  output  8  PWM drive to LEDs, registered.
- busy  output  1  registered; high when any level is non-zero.

Behaviour:
- Reset (res=0, asynchronous): level[0..7]=0, pwm cnt=0, decay div=0, led=8'b0, busy=0. Held while res=0. Normal operation resumes on the first ck edge after res rises. Reset mid-fade discards all levels.
- PWM counter cnt (BW bits): free-running 0..MAX-1, wraps MAX-1 -> 0. PWM period is MAX clocks.
- Decay divider div: counts 0..DECAY_DIV-1, wraps to 0. tick = (div==DECAY_DIV-1). With DECAY_DIV=1, tick is high every cycle.
- Level update, per LED i, at each ck edge:
  - pat[i]=1 -> level[i] <= MAX.
  - else if tick and level[i]!=0 -> level[i] <= level[i]-1.
  - else hold.
  - Load wins over decay when pat[i]=1 coincides with tick.
  - Decrement saturates at 0, no wrap.
- pat is sampled directly every edge, with no input register and no edge detection. A bit held high keeps its level pinned at MAX.
- Output: led[i] <= (level[i] > cnt), registered, evaluated against the pre-edge level and cnt.
  - level=MAX -> led constantly 1.
  - level=0 -> led constantly 0.
  - level=L -> L high cycles per MAX-cycle period, occupying cnt positions 0..L-1.
- busy <= OR over i of (level[i]!=0), registered.
- Latency:
  - pat[i] sampled at edge k -> level[i]=MAX after edge k -> led[i]=1 after edge k+1.
  - Full fade from MAX to 0 takes MAX ticks, i.e. MAX*DECAY_DIV clocks after pat[i] falls.
- All 8 channels are independent. A multi-hot pat is legal; each set bit loads its own channel.
- The divider and cnt never reset except via res; a pat load does not restart them.

Test Plan (BW=4, MAX=15, DECAY_DIV=4):
1. Reset: res=0 with pat=8'hFF toggling clocks -> led=8'h00, busy=0 throughout; release res -> led becomes 8'hFF from the 2nd edge on and stays solid, busy=1.
2. Single pulse: pat=8'h01 for one cycle, then 0 -> level[0]=15, then 14,13,... decrementing every 4 clocks.
   - led[0] duty per 15-clock window tracks the level (e.g. 7 high / 8 low when level=7).
   - Reaches 0 exactly 60 clocks after the last pat cycle; busy falls one clock later.
3. Scan sweep: feed a walking one 01,02,04,...,80 at 1 per 4 clocks -> trailing LEDs show monotonically decreasing duty behind the head; no level below 0 and no wrap to 15.
4. Collision: assert pat[3]=1 on a cycle where tick=1 and level[3]=5 -> level[3]=15, not 4.
5. Held bit: pat=8'h80 held for 100 clocks -> led[7] constant 1, other led bits 0, busy=1.
6. Reset mid-fade: during scenario 2 at level 9, pulse res low asynchronously between edges -> led, busy and all levels clear immediately without waiting for ck; after release, pat=0 keeps led=0.
